// File: rtl/core_rmw_seq.sv
// core_rmw_seq
// Sequences 6502 read-modify-write memory instructions (ASL/LSR/ROL/ROR/INC/DEC)
// around the shared combinational core ALU: bus read, optional dummy write of
// the original value, ALU pass, final write, then a one-cycle completion pulse
// carrying the written value and N/Z/C.
//
// Ports
//   clock, reset            core clock (rising edge), async active-high reset
//   start_valid/ready       request handshake; start_op/addr/carry latched on accept
//   bus_addr/rd/wr/wdata    CPU bus request; bus_rdata/bus_ready response
//   alu_ctl/lhs/carry       ALU operands (idle/zero outside the modify cycle)
//   alu_result/alu_cout     combinational ALU response
//   done_valid              one-cycle completion pulse
//   done_result/n/z/c       last written value and flags, held between completions
//   done_err                qualifies done_valid: illegal opcode, no bus activity
module core_rmw_seq #(
    parameter int unsigned ADDR_W      = 16,
    parameter bit          DUMMY_WRITE = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [3:0]        start_op,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              start_carry,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_rd,
    output logic              bus_wr,
    output logic [7:0]        bus_wdata,
    input  logic [7:0]        bus_rdata,
    input  logic              bus_ready,
    output logic [3:0]        alu_ctl,
    output logic [7:0]        alu_lhs,
    output logic              alu_carry,
    input  logic [7:0]        alu_result,
    input  logic              alu_cout,
    output logic              done_valid,
    output logic [7:0]        done_result,
    output logic              done_n,
    output logic              done_z,
    output logic              done_c,
    output logic              done_err
);

    localparam logic [3:0] OP_ROL = 4'h8;
    localparam logic [3:0] OP_DEC = 4'hD;
    localparam logic [3:0] OP_INC = 4'hC;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_MODIFY,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nx;

    logic [3:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic              carry_q;
    logic              err_q;
    logic [7:0]        data_q;
    logic [7:0]        res_q;
    logic              cout_q;

    logic              accept;
    logic              start_legal;
    logic              modify_adv;
    logic              op_incdec;

    assign start_legal = (start_op >= OP_ROL) && (start_op <= OP_DEC);
    assign accept      = start_valid && start_ready;
    // Without the dummy write the modify cycle has no bus strobe to wait on.
    assign modify_adv  = !DUMMY_WRITE || bus_ready;
    assign op_incdec   = (op_q == OP_INC) || (op_q == OP_DEC);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        start_ready = 1'b0;
        bus_addr    = '0;
        bus_rd      = 1'b0;
        bus_wr      = 1'b0;
        bus_wdata   = '0;
        alu_ctl     = '0;
        alu_lhs     = '0;
        alu_carry   = 1'b0;
        done_valid  = 1'b0;
        done_err    = 1'b0;

        case (state)
            S_IDLE: begin
                start_ready = 1'b1;
                if (accept) begin
                    state_nx = start_legal ? S_READ : S_DONE;
                end
            end
            S_READ: begin
                bus_addr = addr_q;
                bus_rd   = 1'b1;
                if (bus_ready) begin
                    state_nx = S_MODIFY;
                end
            end
            S_MODIFY: begin
                bus_addr  = addr_q;
                alu_ctl   = op_q;
                alu_lhs   = data_q;
                alu_carry = carry_q;
                if (DUMMY_WRITE) begin
                    bus_wr    = 1'b1;
                    bus_wdata = data_q;
                end
                if (modify_adv) begin
                    state_nx = S_WRITE;
                end
            end
            S_WRITE: begin
                bus_addr  = addr_q;
                bus_wr    = 1'b1;
                bus_wdata = res_q;
                if (bus_ready) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                start_ready = 1'b1;
                done_valid  = 1'b1;
                done_err    = err_q;
                if (accept) begin
                    state_nx = start_legal ? S_READ : S_DONE;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q        <= '0;
            addr_q      <= '0;
            carry_q     <= 1'b0;
            err_q       <= 1'b0;
            data_q      <= '0;
            res_q       <= '0;
            cout_q      <= 1'b0;
            done_result <= '0;
            done_n      <= 1'b0;
            done_z      <= 1'b0;
            done_c      <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= start_op;
                addr_q  <= start_addr;
                carry_q <= start_carry;
                err_q   <= !start_legal;
            end
            if (state == S_READ && bus_ready) begin
                data_q <= bus_rdata;
            end
            if (state == S_MODIFY && modify_adv) begin
                res_q  <= alu_result;
                // INC/DEC leave P.C untouched, so the request's carry is returned.
                cout_q <= op_incdec ? carry_q : alu_cout;
            end
            // Completion values only change on a successful final write, so an
            // error completion reports the previous operation's result and flags.
            if (state == S_WRITE && bus_ready) begin
                done_result <= res_q;
                done_n      <= res_q[7];
                done_z      <= (res_q == 8'h00);
                done_c      <= cout_q;
            end
        end
    end

endmodule

// File: tb/tb_core_rmw_seq.sv
module tb_core_rmw_seq;

    logic        clock = 1'b0;
    logic        reset;
    always #5 clock = ~clock;

    // instance with dummy write
    logic        start_valid, start_ready, start_carry;
    logic [3:0]  start_op;
    logic [15:0] start_addr, bus_addr;
    logic        bus_rd, bus_wr, bus_ready;
    logic [7:0]  bus_wdata, bus_rdata;
    logic [3:0]  alu_ctl;
    logic [7:0]  alu_lhs, alu_result;
    logic        alu_carry, alu_cout;
    logic        done_valid, done_n, done_z, done_c, done_err;
    logic [7:0]  done_result;

    // instance without dummy write
    logic        start_valid_1, start_ready_1, start_carry_1;
    logic [3:0]  start_op_1;
    logic [15:0] start_addr_1, bus_addr_1;
    logic        bus_rd_1, bus_wr_1, bus_ready_1;
    logic [7:0]  bus_wdata_1, bus_rdata_1;
    logic [3:0]  alu_ctl_1;
    logic [7:0]  alu_lhs_1, alu_result_1;
    logic        alu_carry_1, alu_cout_1;
    logic        done_valid_1, done_n_1, done_z_1, done_c_1, done_err_1;
    logic [7:0]  done_result_1;

    core_rmw_seq #(.ADDR_W(16), .DUMMY_WRITE(1'b1)) u0 (
        .clock(clock), .reset(reset),
        .start_valid(start_valid), .start_ready(start_ready), .start_op(start_op),
        .start_addr(start_addr), .start_carry(start_carry),
        .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready),
        .alu_ctl(alu_ctl), .alu_lhs(alu_lhs), .alu_carry(alu_carry),
        .alu_result(alu_result), .alu_cout(alu_cout),
        .done_valid(done_valid), .done_result(done_result), .done_n(done_n),
        .done_z(done_z), .done_c(done_c), .done_err(done_err)
    );

    core_rmw_seq #(.ADDR_W(16), .DUMMY_WRITE(1'b0)) u1 (
        .clock(clock), .reset(reset),
        .start_valid(start_valid_1), .start_ready(start_ready_1), .start_op(start_op_1),
        .start_addr(start_addr_1), .start_carry(start_carry_1),
        .bus_addr(bus_addr_1), .bus_rd(bus_rd_1), .bus_wr(bus_wr_1), .bus_wdata(bus_wdata_1),
        .bus_rdata(bus_rdata_1), .bus_ready(bus_ready_1),
        .alu_ctl(alu_ctl_1), .alu_lhs(alu_lhs_1), .alu_carry(alu_carry_1),
        .alu_result(alu_result_1), .alu_cout(alu_cout_1),
        .done_valid(done_valid_1), .done_result(done_result_1), .done_n(done_n_1),
        .done_z(done_z_1), .done_c(done_c_1), .done_err(done_err_1)
    );

    // 6502 shift/rotate/inc/dec semantics; returns {carry_out, result}.
    // INC/DEC carry-out deliberately differs from P.C so a sequencer that
    // forwards it is caught.
    function automatic logic [8:0] alu(input logic [3:0] ctl, input logic [7:0] a, input logic c);
        case (ctl)
            4'h8:    return {a[7], a[6:0], c};
            4'h9:    return {a[0], c, a[7:1]};
            4'hA:    return {a[7], a[6:0], 1'b0};
            4'hB:    return {a[0], 1'b0, a[7:1]};
            4'hC:    return {a == 8'hFF, a + 8'd1};
            4'hD:    return {a != 8'h00, a - 8'd1};
            default: return {1'b0, a};
        endcase
    endfunction

    always_comb {alu_cout, alu_result}     = alu(alu_ctl, alu_lhs, alu_carry);
    always_comb {alu_cout_1, alu_result_1} = alu(alu_ctl_1, alu_lhs_1, alu_carry_1);

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int acc_cyc;
    int last_done;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // expected outputs for one clock cycle
    typedef struct {
        logic        sready, rd, wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [3:0]  ctl;
        logic [7:0]  lhs;
        logic        carry;
        logic        dv, derr;
        logic [7:0]  dres;
        logic        dn, dz, dc;
    } exp_t;

    exp_t q[$];

    // held completion values of the reference model
    logic [7:0] m_res = 8'h00;
    logic       m_n = 1'b0, m_z = 1'b0, m_c = 1'b0;
    bit         pend = 1'b0;
    exp_t       pend_e;

    function automatic exp_t mk_idle();
        exp_t e;
        e.sready = 1'b1; e.rd = 1'b0; e.wr = 1'b0; e.addr = 16'h0; e.wdata = 8'h0;
        e.ctl = 4'h0; e.lhs = 8'h0; e.carry = 1'b0; e.dv = 1'b0; e.derr = 1'b0;
        e.dres = m_res; e.dn = m_n; e.dz = m_z; e.dc = m_c;
        return e;
    endfunction

    function automatic exp_t mk_bus(input logic rd, input logic wr, input logic [15:0] a,
                                    input logic [7:0] wd, input logic [3:0] ctl,
                                    input logic [7:0] lhs, input logic c);
        exp_t e;
        e = mk_idle();
        e.sready = 1'b0; e.rd = rd; e.wr = wr; e.addr = a; e.wdata = wd;
        e.ctl = ctl; e.lhs = lhs; e.carry = c;
        return e;
    endfunction

    always @(negedge clock) begin
        exp_t e;
        if (done_valid) last_done <= cyc;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("start_ready", {15'h0, start_ready}, {15'h0, e.sready});
            chk("bus_rd",      {15'h0, bus_rd},      {15'h0, e.rd});
            chk("bus_wr",      {15'h0, bus_wr},      {15'h0, e.wr});
            chk("bus_addr",    bus_addr,             e.addr);
            chk("bus_wdata",   {8'h0, bus_wdata},    {8'h0, e.wdata});
            chk("alu_ctl",     {12'h0, alu_ctl},     {12'h0, e.ctl});
            chk("alu_lhs",     {8'h0, alu_lhs},      {8'h0, e.lhs});
            chk("alu_carry",   {15'h0, alu_carry},   {15'h0, e.carry});
            chk("done_valid",  {15'h0, done_valid},  {15'h0, e.dv});
            chk("done_err",    {15'h0, done_err},    {15'h0, e.derr});
            chk("done_result", {8'h0, done_result},  {8'h0, e.dres});
            chk("done_n",      {15'h0, done_n},      {15'h0, e.dn});
            chk("done_z",      {15'h0, done_z},      {15'h0, e.dz});
            chk("done_c",      {15'h0, done_c},      {15'h0, e.dc});
        end
    end

    task automatic emit(input logic v, input logic [3:0] op, input logic [15:0] a, input logic c,
                        input logic [7:0] rd, input logic rdy, input exp_t e);
        @(posedge clock); #1;
        start_valid = v; start_op = op; start_addr = a; start_carry = c;
        bus_rdata = rd; bus_ready = rdy;
        q.push_back(e);
    endtask

    // One request: sr/sm/sw are wait-state counts in READ/MODIFY/WRITE.
    // chain=1 presents the request during the previous completion cycle.
    // noise=1 keeps start_valid high while busy.
    task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic c,
                          input logic [7:0] d, input int sr, input int sm, input int sw,
                          input bit chain, input bit noise);
        exp_t       e;
        logic [8:0] ar;
        logic [7:0] r;
        logic       rc;
        if (pend && !chain) begin
            emit(1'b0, 4'h0, 16'h0, 1'b0, 8'h00, 1'b1, pend_e);
            pend = 1'b0;
        end
        e = pend ? pend_e : mk_idle();
        pend = 1'b0;
        emit(1'b1, op, a, c, 8'h00, 1'b1, e);
        acc_cyc = cyc;
        if (op < 4'h8 || op > 4'hD) begin
            pend_e = mk_idle(); pend_e.dv = 1'b1; pend_e.derr = 1'b1; pend = 1'b1;
            return;
        end
        for (int i = 0; i <= sr; i++)
            emit(noise, 4'hB, 16'hBEEF, 1'b1, (i == sr) ? d : ~d, i == sr,
                 mk_bus(1'b1, 1'b0, a, 8'h00, 4'h0, 8'h00, 1'b0));
        ar = alu(op, d, c);
        r  = ar[7:0];
        rc = (op == 4'hC || op == 4'hD) ? c : ar[8];
        for (int i = 0; i <= sm; i++)
            emit(noise, 4'hA, 16'hBEEF, 1'b1, 8'h5A, i == sm,
                 mk_bus(1'b0, 1'b1, a, d, op, d, c));
        for (int i = 0; i <= sw; i++)
            emit(noise, 4'h9, 16'hBEEF, 1'b1, 8'hA5, i == sw,
                 mk_bus(1'b0, 1'b1, a, r, 4'h0, 8'h00, 1'b0));
        m_res = r; m_n = r[7]; m_z = (r == 8'h00); m_c = rc;
        pend_e = mk_idle(); pend_e.dv = 1'b1; pend = 1'b1;
    endtask

    task automatic flush();
        if (pend) begin
            emit(1'b0, 4'h0, 16'h0, 1'b0, 8'h00, 1'b1, pend_e);
            pend = 1'b0;
        end
        emit(1'b0, 4'h0, 16'h0, 1'b0, 8'h00, 1'b1, mk_idle());
        @(negedge clock); #1;
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation still running at %0t, expected finished", $time);
        summary();
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        start_valid = 1'b0; start_op = 4'h0; start_addr = 16'h0; start_carry = 1'b0;
        bus_rdata = 8'h00; bus_ready = 1'b1;
        start_valid_1 = 1'b0; start_op_1 = 4'h0; start_addr_1 = 16'h0; start_carry_1 = 1'b0;
        bus_rdata_1 = 8'h00; bus_ready_1 = 1'b1;

        @(negedge clock); #1;
        chk("rst_start_ready", {15'h0, start_ready}, 16'h1);
        chk("rst_bus_rd",      {15'h0, bus_rd},      16'h0);
        chk("rst_bus_wr",      {15'h0, bus_wr},      16'h0);
        chk("rst_bus_addr",    bus_addr,             16'h0);
        chk("rst_bus_wdata",   {8'h0, bus_wdata},    16'h0);
        chk("rst_alu_ctl",     {12'h0, alu_ctl},     16'h0);
        chk("rst_alu_lhs",     {8'h0, alu_lhs},      16'h0);
        chk("rst_done_valid",  {15'h0, done_valid},  16'h0);
        chk("rst_done_result", {8'h0, done_result},  16'h0);
        @(posedge clock); #1;
        reset = 1'b0;

        // ASL 0x81 -> 0x02, C=1, done 4 cycles after accept
        run_op(4'hA, 16'h0200, 1'b0, 8'h81, 0, 0, 0, 1'b0, 1'b0);
        flush();
        chk("asl_latency", 16'(last_done - acc_cyc), 16'd4);
        chk("asl_result", {8'h0, done_result}, 16'h0002);
        chk("asl_nzc", {13'h0, done_n, done_z, done_c}, 16'b001);

        // INC 0xFF -> 0x00, Z=1, C keeps request carry (0)
        run_op(4'hC, 16'h0010, 1'b0, 8'hFF, 0, 0, 0, 1'b0, 1'b0);
        flush();
        chk("inc_result", {8'h0, done_result}, 16'h0000);
        chk("inc_nzc", {13'h0, done_n, done_z, done_c}, 16'b010);

        // ROR 0x01 carry 1 -> 0x80, N=1 C=1
        run_op(4'h9, 16'h1234, 1'b1, 8'h01, 0, 0, 0, 1'b0, 1'b0);
        flush();
        chk("ror_result", {8'h0, done_result}, 16'h0080);
        chk("ror_nzc", {13'h0, done_n, done_z, done_c}, 16'b101);

        // ROL 0x80 carry 0 -> 0x00, Z=1 C=1
        run_op(4'h8, 16'h8000, 1'b0, 8'h80, 0, 0, 0, 1'b0, 1'b0);
        flush();
        chk("rol_result", {8'h0, done_result}, 16'h0000);
        chk("rol_nzc", {13'h0, done_n, done_z, done_c}, 16'b011);

        // LSR with two read wait states and start_valid asserted while busy
        run_op(4'hB, 16'h00F0, 1'b1, 8'h02, 2, 0, 0, 1'b0, 1'b1);
        flush();
        chk("lsr_latency", 16'(last_done - acc_cyc), 16'd6);
        chk("lsr_result", {8'h0, done_result}, 16'h0001);
        chk("lsr_nzc", {13'h0, done_n, done_z, done_c}, 16'b000);

        // DEC 0x00 with stalls in dummy write and final write
        run_op(4'hD, 16'h0042, 1'b1, 8'h00, 0, 1, 2, 1'b0, 1'b1);
        flush();
        chk("dec_latency", 16'(last_done - acc_cyc), 16'd7);
        chk("dec_result", {8'h0, done_result}, 16'h00FF);
        chk("dec_nzc", {13'h0, done_n, done_z, done_c}, 16'b101);

        // illegal ADC, then back-to-back requests accepted in the completion cycle
        run_op(4'h1, 16'h4444, 1'b0, 8'h00, 0, 0, 0, 1'b0, 1'b0);
        run_op(4'hA, 16'h0300, 1'b0, 8'h40, 0, 0, 0, 1'b1, 1'b0);
        run_op(4'hF, 16'h5555, 1'b1, 8'h00, 0, 0, 0, 1'b1, 1'b0);
        flush();
        chk("chain_result", {8'h0, done_result}, 16'h0080);
        chk("chain_nzc", {13'h0, done_n, done_z, done_c}, 16'b100);

        run_op(4'h1, 16'h6666, 1'b0, 8'h00, 0, 0, 0, 1'b0, 1'b0);
        flush();
        chk("err_latency", 16'(last_done - acc_cyc), 16'd1);

        // reset while the final write is stalled
        emit(1'b1, 4'hC, 16'h0055, 1'b0, 8'h00, 1'b1, mk_idle());
        emit(1'b0, 4'h0, 16'h0, 1'b0, 8'h10, 1'b1, mk_bus(1'b1, 1'b0, 16'h0055, 8'h00, 4'h0, 8'h00, 1'b0));
        emit(1'b0, 4'h0, 16'h0, 1'b0, 8'h00, 1'b1, mk_bus(1'b0, 1'b1, 16'h0055, 8'h10, 4'hC, 8'h10, 1'b0));
        emit(1'b0, 4'h0, 16'h0, 1'b0, 8'h00, 1'b0, mk_bus(1'b0, 1'b1, 16'h0055, 8'h11, 4'h0, 8'h00, 1'b0));
        @(negedge clock); #1;
        reset = 1'b1;
        #1;
        chk("rstw_bus_wr", {15'h0, bus_wr}, 16'h0);
        chk("rstw_start_ready", {15'h0, start_ready}, 16'h1);
        chk("rstw_bus_addr", bus_addr, 16'h0);
        chk("rstw_done_result", {8'h0, done_result}, 16'h0);
        m_res = 8'h00; m_n = 1'b0; m_z = 1'b0; m_c = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0; bus_ready = 1'b1;

        run_op(4'hA, 16'h0077, 1'b0, 8'h01, 0, 0, 0, 1'b0, 1'b0);
        flush();
        chk("post_rst_result", {8'h0, done_result}, 16'h0002);

        // no dummy write: modify cycle has no strobe and ignores bus_ready
        @(posedge clock); #1;
        start_valid_1 = 1'b1; start_op_1 = 4'hD; start_addr_1 = 16'h0300;
        start_carry_1 = 1'b1; bus_rdata_1 = 8'h00; bus_ready_1 = 1'b1;
        acc_cyc = cyc;
        @(posedge clock); #1;
        start_valid_1 = 1'b0;
        @(negedge clock);
        chk("dw0_read_rd", {15'h0, bus_rd_1}, 16'h1);
        chk("dw0_read_addr", bus_addr_1, 16'h0300);
        @(posedge clock); #1;
        bus_ready_1 = 1'b0;
        @(negedge clock);
        chk("dw0_mod_strobes", {14'h0, bus_rd_1, bus_wr_1}, 16'h0);
        chk("dw0_mod_alu", {alu_ctl_1, alu_lhs_1, 3'b0, alu_carry_1}, {4'hD, 8'h00, 4'h1});
        @(posedge clock); #1;
        bus_ready_1 = 1'b1;
        @(negedge clock);
        chk("dw0_write", {7'h0, bus_wr_1, bus_wdata_1}, 16'h01FF);
        begin
            int  k;
            bit  seen;
            seen = 1'b0;
            for (k = 0; k < 10 && !seen; k++) begin
                @(negedge clock);
                if (done_valid_1) seen = 1'b1;
            end
            chk("dw0_done_seen", {15'h0, seen}, 16'h1);
            if (seen) begin
                chk("dw0_latency", 16'(cyc - acc_cyc), 16'd4);
                chk("dw0_result", {8'h0, done_result_1}, 16'h00FF);
                chk("dw0_nzc", {13'h0, done_n_1, done_z_1, done_c_1}, 16'b101);
                chk("dw0_err", {15'h0, done_err_1}, 16'h0);
            end
        end

        summary();
        $finish;
    end

endmodule
